// File: rtl/vscale_regfile_wb_queue_pkg.sv
// Shared sizing, entry layout and helpers for the masked writeback queue.
// XPR_LEN / REG_ADDR_WIDTH come from the opcode header macros when present.
`ifndef XPR_LEN
`define XPR_LEN 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

package vscale_regfile_wb_queue_pkg;

    localparam int unsigned XPR_LEN        = `XPR_LEN;
    localparam int unsigned REG_ADDR_WIDTH = `REG_ADDR_WIDTH;
    localparam int unsigned SHARES_DEFAULT = 2;
    localparam int unsigned DEPTH_DEFAULT  = 2;

    // Bits of fresh randomness consumed per refreshed word.
    function automatic int unsigned rnd_width(input int unsigned shares);
        return XPR_LEN * (shares - 1);
    endfunction

    // Queue entry for the default share count.
    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0]         wa;
        logic [XPR_LEN*SHARES_DEFAULT-1:0] wd;
    } wb_entry_t;

endpackage

// File: rtl/vscale_share_refresh.sv
// Combinational share refresh: every share but the last absorbs one random word,
// the last absorbs the XOR of all of them, so the unmasked value is unchanged.
module vscale_share_refresh
    import vscale_regfile_wb_queue_pkg::*;
#(
    parameter int unsigned SHARES = SHARES_DEFAULT
) (
    input  logic [XPR_LEN*SHARES-1:0]     wd,
    input  logic [XPR_LEN*(SHARES-1)-1:0] rnd,
    output logic [XPR_LEN*SHARES-1:0]     wd_c
);

    logic [XPR_LEN-1:0] rnd_acc;

    always_comb begin
        wd_c    = '0;
        rnd_acc = '0;
        for (int i = 0; i < int'(SHARES) - 1; i++) begin
            wd_c[i*XPR_LEN +: XPR_LEN] = wd[i*XPR_LEN +: XPR_LEN] ^ rnd[i*XPR_LEN +: XPR_LEN];
            rnd_acc                    = rnd_acc ^ rnd[i*XPR_LEN +: XPR_LEN];
        end
        wd_c[(SHARES-1)*XPR_LEN +: XPR_LEN] = wd[(SHARES-1)*XPR_LEN +: XPR_LEN] ^ rnd_acc;
    end

endmodule

// File: rtl/vscale_regfile_wb_queue.sv
// Masked writeback FIFO in front of the regfile write port, with share refresh
// and RAW hazard reporting. Define VSCALE_WB_BYPASS_EN to add forwarding ports.
module vscale_regfile_wb_queue
    import vscale_regfile_wb_queue_pkg::*;
#(
    parameter int unsigned SHARES = SHARES_DEFAULT,
    parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [REG_ADDR_WIDTH-1:0]     in_wa,
    input  logic [XPR_LEN*SHARES-1:0]     in_wd,
    input  logic                          rnd_valid,
    output logic                          rnd_ready,
    input  logic [XPR_LEN*(SHARES-1)-1:0] rnd,
    output logic                          wen,
    output logic [REG_ADDR_WIDTH-1:0]     wa,
    output logic [XPR_LEN*SHARES-1:0]     wd,
    input  logic [REG_ADDR_WIDTH-1:0]     ra1,
    input  logic [REG_ADDR_WIDTH-1:0]     ra2,
    output logic                          haz1,
    output logic                          haz2
`ifdef VSCALE_WB_BYPASS_EN
    ,
    output logic                          byp1_valid,
    output logic                          byp2_valid,
    output logic [XPR_LEN*SHARES-1:0]     byp1_data,
    output logic [XPR_LEN*SHARES-1:0]     byp2_data
`endif
);

    localparam int unsigned WD_W  = XPR_LEN * SHARES;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [REG_ADDR_WIDTH-1:0] fifo_wa [DEPTH];
    logic [WD_W-1:0]           fifo_wd [DEPTH];
    logic [PTR_W-1:0]          rd_ptr;
    logic [PTR_W-1:0]          wr_ptr;
    logic [CNT_W-1:0]          count;
    logic                      push;
    logic                      drain;
    logic [WD_W-1:0]           wd_refreshed_c;
    logic [PTR_W-1:0]          slot;

    assign in_ready  = count < CNT_W'(DEPTH);
    assign drain     = (count != '0) && rnd_valid;
    assign rnd_ready = drain;
    // Writes to x0 are acknowledged but never queued.
    assign push      = in_valid && in_ready && (in_wa != '0);

    vscale_share_refresh #(
        .SHARES (SHARES)
    ) u_refresh (
        .wd   (fifo_wd[rd_ptr]),
        .rnd  (rnd),
        .wd_c (wd_refreshed_c)
    );

    // Entry storage needs no reset; validity is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wa[wr_ptr] <= in_wa;
            fifo_wd[wr_ptr] <= in_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            wen    <= 1'b0;
            wa     <= '0;
            wd     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (drain) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                wa     <= fifo_wa[rd_ptr];
                wd     <= wd_refreshed_c;
            end
            case ({push, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            wen <= drain;
        end
    end

    // Hazard scan from oldest to youngest so later hits override earlier data.
    always_comb begin
        haz1 = wen && (wa == ra1);
        haz2 = wen && (wa == ra2);
        slot = '0;
`ifdef VSCALE_WB_BYPASS_EN
        byp1_data = wd;
        byp2_data = wd;
`endif
        for (int k = 0; k < int'(DEPTH); k++) begin
            slot = rd_ptr + PTR_W'(k);
            if (CNT_W'(k) < count) begin
                if (fifo_wa[slot] == ra1) begin
                    haz1 = 1'b1;
`ifdef VSCALE_WB_BYPASS_EN
                    byp1_data = fifo_wd[slot];
`endif
                end
                if (fifo_wa[slot] == ra2) begin
                    haz2 = 1'b1;
`ifdef VSCALE_WB_BYPASS_EN
                    byp2_data = fifo_wd[slot];
`endif
                end
            end
        end
        if (ra1 == '0) begin
            haz1 = 1'b0;
        end
        if (ra2 == '0) begin
            haz2 = 1'b0;
        end
    end

`ifdef VSCALE_WB_BYPASS_EN
    assign byp1_valid = haz1;
    assign byp2_valid = haz2;
`endif

endmodule
